// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART receive and transmit paths:
//                frame geometry, default bit period and the receive FSM state
//                encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Data bits per frame. The frame has no configurable width.
  localparam int DATA_BITS = 8;

  // Bit period in clock cycles for 115200 baud from a 50 MHz clock.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Receive FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_bit_timer
//  Description : Bit-period counter for the UART receiver. Counts
//                0..CLKS_PER_BIT-1 and wraps; flags the half-bit and
//                full-bit positions.
//  Ports       : clk          - system clock
//                reset        - synchronous, active-low reset
//                clear_i      - force the counter to 0 (wins over enable_i)
//                enable_i     - advance the counter
//                half_tick_o  - counter at CLKS_PER_BIT/2-1 while enabled
//                full_tick_o  - counter at CLKS_PER_BIT-1 while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == FULL_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = enable_i && (cnt_q == HALF_LAST);
  assign full_tick_o = enable_i && (cnt_q == FULL_LAST);

endmodule : uart_rx_bit_timer
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deframer
//  Description : UART receiver. Recovers 1 start + 8 data (LSB first) +
//                optional parity + 1 stop frames from an asynchronous line.
//  Ports       : clk          - system clock
//                reset        - synchronous, active-low reset
//                uart_rx_pin  - asynchronous serial input, idles high
//                Parity_En    - a parity bit follows data bit 7
//                Parity_Odd   - 1 = odd parity, 0 = even parity
//                UART_Rx      - [7:0] data, [8] received parity bit
//                RX_Parity    - parity error for the last frame
//                Frame_Err    - stop bit sampled low in the last frame
//                UART_Rx_Done - one-cycle strobe, outputs valid from it on
//                Rx_Busy      - high from start detection until back in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uart_rx_pin,
  input  logic             Parity_En,
  input  logic             Parity_Odd,
  output logic [DATA_BITS:0] UART_Rx,
  output logic             RX_Parity,
  output logic             Frame_Err,
  output logic             UART_Rx_Done,
  output logic             Rx_Busy
);

  localparam int             IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Two-stage synchroniser; resets to the idle (high) line level.
  logic [1:0] sync_q;
  logic       rx_s;

  uart_rx_state_e         state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_bit_q;
  logic [DATA_BITS:0]     rx_word_q;
  logic                   par_err_q;
  logic                   frame_err_q;
  logic                   done_q;
  logic                   busy_q;

  logic                   timer_clr;
  logic                   timer_en;
  logic                   half_tick;
  logic                   full_tick;
  logic                   par_err_calc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_pin};
    end
  end

  assign rx_s = sync_q[1];

  // The counter is held at 0 outside the sampling states so that it starts
  // from 0 on the first cycle of START, and is re-zeroed at mid-start-bit so
  // that every later sample lands in the middle of its bit.
  assign timer_en  = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign timer_clr = (state_q == ST_IDLE) || (state_q == ST_BREAK) ||
                     ((state_q == ST_START) && half_tick);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (timer_clr),
    .enable_i    (timer_en),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick)
  );

  // Even/odd check over the data, the received parity bit and the latched
  // mode; forced to 0 when the frame carried no parity bit.
  assign par_err_calc = par_en_q & ((^shift_q) ^ par_bit_q ^ par_odd_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      rx_word_q   <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            par_en_q  <= Parity_En;
            par_odd_q <= Parity_Odd;
            par_bit_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (half_tick) begin
            if (!rx_s) begin
              state_q <= ST_DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            par_bit_q <= rx_s;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            rx_word_q   <= {par_en_q & par_bit_q, shift_q};
            par_err_q   <= par_err_calc;
            frame_err_q <= ~rx_s;
            done_q      <= 1'b1;
            // A low stop bit may be the start of a break; hold off new
            // start detection until the line goes high again.
            busy_q      <= ~rx_s;
            state_q     <= rx_s ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign UART_Rx      = rx_word_q;
  assign RX_Parity    = par_err_q;
  assign Frame_Err    = frame_err_q;
  assign UART_Rx_Done = done_q;
  assign Rx_Busy      = busy_q;

endmodule : uart_rx_deframer
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_deframer
//  Description : Self-checking bench for uart_rx_deframer at 16 clocks/bit.
//                A table of frames plus hand-written break, glitch,
//                back-to-back and mid-frame reset sequences. Expected frame
//                results are queued when a frame is driven and compared when
//                the strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deframer;

  localparam int CPB = 16;
  // Cycles from the last clock edge before the pin falls to the edge that
  // raises the strobe: the first edge that sees the low pin, two more
  // (synchroniser), half a bit, then nine full bits (8 data + stop).
  localparam int LAT = 1 + 2 + CPB / 2 + 9 * CPB;

  logic       clk         = 1'b0;
  logic       reset       = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       Parity_En   = 1'b0;
  logic       Parity_Odd  = 1'b0;
  logic [8:0] UART_Rx;
  logic       RX_Parity;
  logic       Frame_Err;
  logic       UART_Rx_Done;
  logic       Rx_Busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;

  typedef struct {
    logic [8:0] rx;
    logic       par;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       po;
    logic       pbit;
    logic       flip;
    logic [8:0] rx;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx_pin  (uart_rx_pin),
    .Parity_En    (Parity_En),
    .Parity_Odd   (Parity_Odd),
    .UART_Rx      (UART_Rx),
    .RX_Parity    (RX_Parity),
    .Frame_Err    (Frame_Err),
    .UART_Rx_Done (UART_Rx_Done),
    .Rx_Busy      (Rx_Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx_pin = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Must be called at a falling clock edge; returns at one.
  task automatic send_frame(input logic [7:0] data, input logic pe, input logic po,
                            input logic pbit, input logic stopb, input int idle_bits,
                            input logic flip, input logic [8:0] exp_rx,
                            input logic exp_par, input logic exp_ferr);
    exp_t e;
    Parity_En  = pe;
    Parity_Odd = po;
    e.rx   = exp_rx;
    e.par  = exp_par;
    e.ferr = exp_ferr;
    e.cyc  = cyc + LAT + (pe ? CPB : 0);
    sb.push_back(e);
    drive_bit(1'b0);
    if (flip) begin
      Parity_En  = ~pe;
      Parity_Odd = ~po;
    end
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stopb);
    repeat (idle_bits) drive_bit(1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 * CPB && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Strobe monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (UART_Rx_Done === 1'b1) begin
        strobes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: UART_Rx=0x%0h at cycle %0d, expected no strobe",
                   UART_Rx, cyc);
        end else begin
          e = sb.pop_front();
          check("rx_word", UART_Rx, e.rx);
          check("rx_parity", RX_Parity, e.par);
          check("frame_err", Frame_Err, e.ferr);
          check("strobe_cycle", cyc, e.cyc);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", UART_Rx_Done, 1'b0);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    //            data   pe    po    pbit  flip  rx       par
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 9'h003, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 9'h103, 1'b1};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 9'h103, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 9'h181, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 9'h17E, 1'b1};
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 9'h05A, 1'b0};
    vecs[7] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0F0, 1'b1};

    // Reset state
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_rx", UART_Rx, 9'h000);
    check("reset_parity", RX_Parity, 1'b0);
    check("reset_ferr", Frame_Err, 1'b0);
    check("reset_done", UART_Rx_Done, 1'b0);
    check("reset_busy", Rx_Busy, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Table of normal frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].pbit, 1'b1, 2,
                 vecs[i].flip, vecs[i].rx, vecs[i].par, 1'b0);
      drain($sformatf("drain_vec%0d", i));
    end

    // Framing error followed by a 40-bit break
    s0 = strobes;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 9'h055, 1'b0, 1'b1);
    uart_rx_pin = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("busy_in_break", Rx_Busy, 1'b1);
    repeat (20 * CPB) @(negedge clk);
    uart_rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_after_break", Rx_Busy, 1'b0);
    drain("drain_break");
    check("break_strobes", strobes - s0, 1);
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 9'h012, 1'b0, 1'b0);
    drain("drain_after_break");

    // Four-cycle glitch
    s0 = strobes;
    uart_rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch_busy_sync", Rx_Busy, 1'b0);
    @(negedge clk);
    check("glitch_busy_rise", Rx_Busy, 1'b1);
    @(negedge clk);
    uart_rx_pin = 1'b1;
    for (int i = 0; i < 16 && Rx_Busy !== 1'b0; i++) @(negedge clk);
    check("glitch_busy_clear", Rx_Busy, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_strobes", strobes - s0, 0);
    check("glitch_rx_hold", UART_Rx, 9'h012);
    check("glitch_ferr_hold", Frame_Err, 1'b0);

    // Back-to-back frames with no idle gap
    s0 = strobes;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 9'h000, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 9'h0FF, 1'b0, 1'b0);
    drain("drain_b2b");
    check("b2b_strobes", strobes - s0, 2);

    // Reset during data bit 4 of 0x3C (bits 0..3 = 0,0,1,1; bit 4 = 1)
    s0 = strobes;
    uart_rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    uart_rx_pin = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("midreset_strobes", strobes - s0, 0);
    check("midreset_rx", UART_Rx, 9'h000);
    check("midreset_parity", RX_Parity, 1'b0);
    check("midreset_ferr", Frame_Err, 1'b0);
    check("midreset_busy", Rx_Busy, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 9'h0C3, 1'b0, 1'b0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_deframer
`default_nettype wire
